// File: rtl/pixel_clip_fifo.sv
// rtl/pixel_clip_fifo.sv - clips circle plot stream to the visible area, buffers it, drains to a stallable framebuffer port
// Optional: define PIXEL_STATS_EN to add stat_written / stat_clipped counters.
module pixel_clip_fifo #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_plot,
  input  logic       in_done,
  output logic       in_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  input  logic       vga_ready,
  output logic       out_done,
  output logic       overflow
`ifdef PIXEL_STATS_EN
  ,
  output logic [15:0] stat_written,
  output logic [15:0] stat_clipped
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PIX_W = 18;
  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [7:0] H_LIM = 8'(SCREEN_H);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  logic [PIX_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PIX_W-1:0] head_q, head_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             in_done_q;
  state_t           state_q, state_d;
  logic             out_done_q, out_done_d;

  logic visible, full, push, pop, load, done_rise;

  // Clip, handshake and occupancy bookkeeping; occupancy includes the output register
  always_comb begin
    visible   = in_plot && ({1'b0, in_x} < W_LIM) && ({1'b0, in_y} < H_LIM);
    full      = (occ_q == CAP);
    pop       = out_valid_q && vga_ready;
    push      = visible && (!full || pop);
    fifo_cnt  = occ_q - CNT_W'(out_valid_q);
    load      = (fifo_cnt != '0) && (!out_valid_q || pop);
    done_rise = in_done && !in_done_q;

    occ_d = occ_q;
    if (push && !pop)
      occ_d = occ_q + CNT_W'(1);
    else if (!push && pop)
      occ_d = occ_q - CNT_W'(1);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    head_d      = load ? mem[rd_ptr_q] : head_q;
    out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    overflow_d  = overflow_q || (visible && full && !pop);
  end

  // Storage array is plain memory; pointers alone define what is valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  // Datapath registers: pointers, occupancy, output head and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_done_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      in_done_q   <= in_done;
    end
  end

  // Next-state for the done tracker; DONE is entered once nothing remains after this edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (done_rise)
          state_d = (occ_d == '0) ? DONE : DRAIN;
        else if (in_plot)
          state_d = RUN;
      end
      RUN:   if (done_rise) state_d = DRAIN;
      DRAIN: if (occ_d == '0) state_d = DONE;
      DONE:  if (!in_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_done_d = (state_d == DONE);
  end

  // Done tracker state with registered out_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      out_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_done_q <= out_done_d;
    end
  end

  assign in_ready   = !full || pop;
  assign vga_x      = head_q[17:10];
  assign vga_y      = head_q[9:3];
  assign vga_colour = head_q[2:0];
  assign vga_plot   = out_valid_q;
  assign out_done   = out_done_q;
  assign overflow   = overflow_q;

`ifdef PIXEL_STATS_EN
  logic [15:0] written_q, written_d;
  logic [15:0] clipped_q, clipped_d;
  logic        stat_clear;

  // Saturating counters, cleared when a finished circle hands over to the next one
  always_comb begin
    stat_clear = (state_q == DONE) && !in_done;
    written_d  = written_q;
    clipped_d  = clipped_q;
    if (stat_clear) begin
      written_d = '0;
      clipped_d = '0;
    end else begin
      if (pop && written_q != 16'hFFFF)
        written_d = written_q + 16'd1;
      if (in_plot && !visible && clipped_q != 16'hFFFF)
        clipped_d = clipped_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      written_q <= written_d;
      clipped_q <= clipped_d;
    end
  end

  assign stat_written = written_q;
  assign stat_clipped = clipped_q;
`endif

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// tb/tb_pixel_clip_fifo.sv - directed self-checking bench for pixel_clip_fifo
module tb_pixel_clip_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic       in_done;
  logic       in_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       vga_ready;
  logic       out_done;
  logic       overflow;
`ifdef PIXEL_STATS_EN
  logic [15:0] stat_written;
  logic [15:0] stat_clipped;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [17:0] wq [$];
  logic [17:0] q_pix;

  pixel_clip_fifo dut (
    .clk(clk), .rst(rst),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
    .in_done(in_done), .in_ready(in_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .vga_ready(vga_ready), .out_done(out_done), .overflow(overflow)
`ifdef PIXEL_STATS_EN
    , .stat_written(stat_written), .stat_clipped(stat_clipped)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && vga_plot && vga_ready)
      wq.push_back({vga_x, vga_y, vga_colour});
  end

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int c, input logic p);
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
    in_plot   = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
  endtask

  logic [17:0] t1 [4];

  initial begin
    rst = 1'b1;
    in_done = 1'b0;
    vga_ready = 1'b0;
    drive(0, 0, 0, 1'b0);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_vga_plot", 32'(vga_plot), 32'd0);
    check("rst_vga_pix", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_out_done", 32'(out_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;

    // 1: four visible pixels with ready high, each appears one cycle after its push
    t1[0] = pix(10, 20, 3);
    t1[1] = pix(159, 119, 7);
    t1[2] = pix(0, 0, 1);
    t1[3] = pix(80, 60, 2);
    vga_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(t1[i][17:10], t1[i][9:3], t1[i][2:0], 1'b1);
      else       drive(0, 0, 0, 1'b0);
      tick();
      if (i >= 1) begin
        check($sformatf("t1_plot_%0d", i - 1), 32'(vga_plot), 32'd1);
        check($sformatf("t1_pix_%0d", i - 1), 32'({vga_x, vga_y, vga_colour}), 32'(t1[i - 1]));
      end
    end
    tick();
    check("t1_write_count", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < wq.size()) check($sformatf("t1_order_%0d", i), 32'(wq[i]), 32'(t1[i]));
    check("t1_overflow", 32'(overflow), 32'd0);

    // 2: clipped pixels and a non-plot cycle never produce a write
    drive(160, 5, 1, 1'b1);   tick(); check("t2_plot_a", 32'(vga_plot), 32'd0);
    drive(5, 120, 2, 1'b1);   tick(); check("t2_plot_b", 32'(vga_plot), 32'd0);
    drive(255, 127, 3, 1'b1); tick(); check("t2_plot_c", 32'(vga_plot), 32'd0);
    drive(3, 3, 4, 1'b0);     tick(); check("t2_plot_d", 32'(vga_plot), 32'd0);
    tick();
    check("t2_plot_e", 32'(vga_plot), 32'd0);
    check("t2_write_count", 32'(wq.size()), 32'd4);
`ifdef PIXEL_STATS_EN
    check("t2_stat_clipped", 32'(stat_clipped), 32'd3);
    check("t2_stat_written", 32'(stat_written), 32'd4);
`endif

    // 3: stalled sink, 20 pushes: 17 accepted, overflow from the 18th, then drain in order
    do_reset();
    vga_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(k + 1, k + 2, k % 8, 1'b1);
      #1;
      check($sformatf("t3_in_ready_%0d", k), 32'(in_ready), (k < 17) ? 32'd1 : 32'd0);
      tick();
      if (k == 16 || k == 17)
        check($sformatf("t3_overflow_%0d", k), 32'(overflow), (k >= 17) ? 32'd1 : 32'd0);
      if (k == 1 || k == 19)
        check($sformatf("t3_stall_hold_%0d", k), 32'({vga_plot, vga_x, vga_y, vga_colour}),
              32'({1'b1, pix(1, 2, 0)}));
    end
    drive(0, 0, 0, 1'b0);
    vga_ready = 1'b1;
    for (int c = 0; c < 25; c++) tick();
    check("t3_write_count", 32'(wq.size()), 32'd17);
    for (int k = 0; k < 17; k++)
      if (k < wq.size()) check($sformatf("t3_order_%0d", k), 32'(wq[k]), 32'(pix(k + 1, k + 2, k % 8)));
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: full FIFO, push coincident with a pop is accepted without overflow
    do_reset();
    vga_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive(k + 1, k + 2, k % 8, 1'b1);
      tick();
    end
    drive(0, 0, 0, 1'b0);
    #1;
    check("t4_full_in_ready", 32'(in_ready), 32'd0);
    q_pix = pix(100, 100, 5);
    drive(100, 100, 5, 1'b1);
    vga_ready = 1'b1;
    #1;
    check("t4_popfree_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("t4_overflow", 32'(overflow), 32'd0);
    drive(0, 0, 0, 1'b0);
    for (int c = 0; c < 25; c++) tick();
    check("t4_write_count", 32'(wq.size()), 32'd18);
    if (wq.size() == 18) check("t4_last_pix", 32'(wq[17]), 32'(q_pix));
    check("t4_overflow_end", 32'(overflow), 32'd0);

    // 5: out_done waits for the last transfer and drops with in_done
    do_reset();
    vga_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(20 + k, 30 + k, k + 1, 1'b1);
      tick();
    end
    drive(0, 0, 0, 1'b0);
    in_done = 1'b1;
    tick(); tick();
    check("t5_done_stalled", 32'(out_done), 32'd0);
    vga_ready = 1'b1;
    tick(); check("t5_done_after_1", 32'(out_done), 32'd0);
    tick(); check("t5_done_after_2", 32'(out_done), 32'd0);
    tick(); check("t5_done_after_3", 32'(out_done), 32'd1);
    check("t5_write_count", 32'(wq.size()), 32'd3);
    in_done = 1'b0;
    tick();
    check("t5_done_dropped", 32'(out_done), 32'd0);
`ifdef PIXEL_STATS_EN
    check("t5_stat_cleared", 32'(stat_written), 32'd0);
`endif

    // 6: asynchronous reset with 5 pixels queued discards everything
    vga_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(40 + k, 50 + k, k, 1'b1);
      tick();
    end
    drive(0, 0, 0, 1'b0);
    check("t6_plot_before", 32'(vga_plot), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_plot", 32'(vga_plot), 32'd0);
    check("t6_async_pix", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("t6_async_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    wq.delete();
    vga_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("t6_no_write", 32'(wq.size()), 32'd0);
    check("t6_plot_after", 32'(vga_plot), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_clip_fifo.md
Name: pixel_clip_fifo

Overview:
Downstream stage between the circle drawer and the VGA framebuffer write port. It accepts the plot stream (x, y, colour, plot strobe) from circle. It discards pixels outside the 160x120 visible area and buffers the rest in a FIFO. It then drains them to a framebuffer write port that can stall through a ready signal. It also forwards circle's done as out_done, asserted only once every accepted pixel has been written.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_x  input  8  pixel x from circle (vga_x)
in_y  input  7  pixel y from circle (vga_y)
in_colour  input  3  pixel colour from circle (vga_colour)
in_plot  input  1  pixel valid strobe from circle (vga_plot)
in_done  input  1  circle done level
in_ready  output  1  high when FIFO not full; advisory, circle has no stall
vga_x  output  8  framebuffer write x
vga_y  output  7  framebuffer write y
vga_colour  output  3  framebuffer write colour
vga_plot  output  1  framebuffer write valid
vga_ready  input  1  framebuffer accepts write this cycle
out_done  output  1  upstream done and all pixels drained
overflow  output  1  sticky: a visible pixel was dropped because the FIFO was full

Behaviour:
- Reset, asynchronous, rst=1:
  - FIFO empty, in_ready=1.
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - out_done=0, overflow=0.
  - State IDLE.
- Reset mid-operation discards all queued pixels. Nothing is written after rst asserts.
- Clip (combinational on the input): visible = in_plot && in_x < SCREEN_W && in_y < SCREEN_H.
  - Clipped pixels are never stored and have no other effect.
- Push happens on a rising edge when visible && !full. If visible && full, the pixel is dropped and overflow sets; it stays set until reset.
- Output is a registered head with first-word-fall-through behaviour:
  - vga_plot=1 whenever the output register holds a pixel.
  - A transfer occurs when vga_plot && vga_ready.
  - When vga_plot && !vga_ready, vga_x, vga_y and vga_colour hold stable.
- Latency: a visible pixel pushed into an empty FIFO at edge N appears on vga_* with vga_plot=1 after edge N+1.
- Throughput: with vga_ready held high, one pixel per cycle is sustained. The output register refills in the same cycle it transfers.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and overflow does not set. in_ready = !full || (vga_plot && vga_ready).
- Occupancy counter is $clog2(DEPTH)+1 bits. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy counts FIFO entries plus the output register, so total capacity is DEPTH+1 pixels.
- State machine:
  - IDLE: go to RUN on the first in_plot.
  - RUN: go to DRAIN when in_done rises (0 to 1).
  - DRAIN: when FIFO empty and no vga_plot pending, go to DONE.
  - DONE: out_done=1. Go to IDLE when in_done falls (0), which is the start of the next circle.
  - in_done rising while in IDLE, with no pixels seen: go straight to DONE on the next edge.
- Pixels that arrive during DRAIN are still accepted and must drain before DONE.

Optional Feature:
PIXEL_STATS_EN
- Defined, adds two outputs:
  - stat_written, 16 bits: transfers completed.
  - stat_clipped, 16 bits: in_plot pulses rejected by the clip.
- Both counters reset to 0 and saturate at 16'hFFFF. They clear on the DONE-to-IDLE transition.
- Undefined: the outputs and counters do not exist and port lists omit them.

Test Plan:
1. Reset, then 4 pixels (10,20,c=3), (159,119,c=7), (0,0,c=1), (80,60,c=2) with vga_ready=1:
   - Exactly 4 writes, in order, each one cycle after its push.
   - overflow=0.
2. Pixels (160,5), (5,120), (255,127) and in_plot=0 with x=3,y=3:
   - No write ever occurs.
   - stat_clipped=3 if PIXEL_STATS_EN.
3. vga_ready=0, then 20 consecutive visible pixels with DEPTH=16:
   - First 17 accepted, overflow=1 from the 18th.
   - Release ready: exactly 17 writes, in order, vga_* stable while stalled.
4. FIFO full, then a push in the same cycle vga_ready=1 pops:
   - Push accepted, overflow stays 0.
   - Written count equals pushed count.
5. 3 pixels queued with vga_ready=0, then in_done=1:
   - out_done stays 0 until the third transfer.
   - out_done=1 the cycle after, and 0 after in_done drops.
6. rst pulsed while 5 pixels are queued:
   - All outputs return to reset values immediately (asynchronous).
   - No write after reset, and the FIFO is empty.
